// File: rtl/seed_stream_reader.sv
// Streams the expanded WOTS secret seeds out of the seed memory in address order.
// A 2-entry prefetch FIFO hides the one-cycle read latency and downstream backpressure.
module seed_stream_reader #(
   parameter int SEED_NUM = 67,
   parameter int KEY_LEN  = 256,
   parameter int ADDR_W   = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               seed_mem_rd_en,
   output logic [ADDR_W-1:0]  seed_mem_rd_addr,
   input  logic [KEY_LEN-1:0] seed_mem_rd_data,
   output logic [KEY_LEN-1:0] seed_out,
   output logic [ADDR_W-1:0]  seed_out_index,
   output logic               seed_out_valid,
   input  logic               seed_out_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } state_t;

   // One extra bit so SEED_NUM equal to a power of two does not wrap.
   localparam logic [ADDR_W:0] SEED_CNT = (ADDR_W + 1)'(SEED_NUM);
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(SEED_NUM - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   state_t              state;
   logic [ADDR_W:0]     issue_cnt;
   logic [ADDR_W:0]     accept_cnt;
   logic                inflight;
   logic [ADDR_W-1:0]   inflight_addr;
   logic [ADDR_W-1:0]   last_addr;
   logic [KEY_LEN-1:0]  tail_data;
   logic [ADDR_W-1:0]   tail_index;
   logic                tail_valid;
   logic                pop;
   logic                push;
   logic [1:0]          fifo_count;
   logic [2:0]          occupancy;

   // Read credit: FIFO entries plus the in-flight read, less the entry leaving this cycle.
   always_comb begin
      pop        = seed_out_valid && seed_out_ready;
      push       = inflight;
      fifo_count = {1'b0, seed_out_valid} + {1'b0, tail_valid};
      occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
      if ((state == STREAM) && (issue_cnt < SEED_CNT) && (occupancy < 3'd2)) begin
         seed_mem_rd_en = 1'b1;
      end else begin
         seed_mem_rd_en = 1'b0;
      end
      if (seed_mem_rd_en) begin
         seed_mem_rd_addr = issue_cnt[ADDR_W-1:0];
      end else begin
         seed_mem_rd_addr = last_addr;
      end
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         issue_cnt  <= '0;
         accept_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= STREAM;
                  busy       <= 1'b1;
                  issue_cnt  <= '0;
                  accept_cnt <= '0;
               end
            end
            STREAM: begin
               if (seed_mem_rd_en) begin
                  issue_cnt <= issue_cnt + CNT_ONE;
               end
               if (pop) begin
                  accept_cnt <= accept_cnt + CNT_ONE;
                  if (accept_cnt == LAST_IDX) begin
                     state <= FINISH;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Track the outstanding read so its data can be tagged when it returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight      <= 1'b0;
         inflight_addr <= '0;
         last_addr     <= '0;
      end else begin
         inflight <= seed_mem_rd_en;
         if (seed_mem_rd_en) begin
            inflight_addr <= seed_mem_rd_addr;
            last_addr     <= seed_mem_rd_addr;
         end
      end
   end

   // Two-entry FIFO: the head registers drive the outputs directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         seed_out       <= '0;
         seed_out_index <= '0;
         seed_out_valid <= 1'b0;
         tail_data      <= '0;
         tail_index     <= '0;
         tail_valid     <= 1'b0;
      end else if (pop) begin
         if (tail_valid) begin
            seed_out       <= tail_data;
            seed_out_index <= tail_index;
            seed_out_valid <= 1'b1;
            tail_valid     <= push;
            if (push) begin
               tail_data  <= seed_mem_rd_data;
               tail_index <= inflight_addr;
            end
         end else if (push) begin
            seed_out       <= seed_mem_rd_data;
            seed_out_index <= inflight_addr;
            seed_out_valid <= 1'b1;
         end else begin
            seed_out_valid <= 1'b0;
         end
      end else if (push) begin
         if (!seed_out_valid) begin
            seed_out       <= seed_mem_rd_data;
            seed_out_index <= inflight_addr;
            seed_out_valid <= 1'b1;
         end else begin
            tail_data  <= seed_mem_rd_data;
            tail_index <= inflight_addr;
            tail_valid <= 1'b1;
         end
      end else begin
         seed_out_valid <= seed_out_valid;
      end
   end

   seed_stream_reader_checks u_checks (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .fifo_count (fifo_count)
   );

endmodule

// Simulation-only guard: a push into a full FIFO without a pop is a credit bug.
module seed_stream_reader_checks (
   input logic       clk,
   input logic       reset,
   input logic       push,
   input logic       pop,
   input logic [1:0] fifo_count
);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (fifo_count == 2'd2)))
      else $error("seed_stream_reader: prefetch FIFO overflow");

endmodule

// File: tb/tb_seed_stream_reader.sv
// Directed bench for seed_stream_reader: scenario table on a 67-seed instance,
// plus reset-abort and SEED_NUM=1 / SEED_NUM=64 sequences.
module tb_seed_stream_reader;

   typedef struct {
      int mode;            // 0 ready high, 1 stall then high, 2 LFSR ready
      int stall;           // ready low while cycle <= stall (mode 1)
      int restart;         // pulse start again at cycle 30 and in the FINISH cycle
      int exp_first_valid;
      int exp_done;        // -1: not checked
      int exp_busy;        // -1: not checked
      int exp_stall_rd;    // -1: not checked
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         ready = 1'b0;
   logic         busy, done, rd_en, valid;
   logic [6:0]   rd_addr, idx;
   logic [255:0] rd_data, seed_out;

   logic         start_small = 1'b0;
   logic         ready_small = 1'b1;
   logic         s1_busy, s1_done, s1_rd_en, s1_valid;
   logic [0:0]   s1_addr, s1_idx;
   logic [255:0] s1_rd_data, s1_seed;
   logic         s64_busy, s64_done, s64_rd_en, s64_valid;
   logic [5:0]   s64_addr, s64_idx;
   logic [255:0] s64_rd_data, s64_seed;

   int           cyc = 0;
   int           nvec = 0;
   int           nerr = 0;
   logic [15:0]  lfsr = 16'hACE1;

   seed_stream_reader #(.SEED_NUM(67), .KEY_LEN(256)) dut (
      .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
      .seed_mem_rd_en(rd_en), .seed_mem_rd_addr(rd_addr), .seed_mem_rd_data(rd_data),
      .seed_out(seed_out), .seed_out_index(idx), .seed_out_valid(valid),
      .seed_out_ready(ready)
   );

   seed_stream_reader #(.SEED_NUM(1), .KEY_LEN(256)) dut1 (
      .clk(clk), .reset(rst), .start(start_small), .busy(s1_busy), .done(s1_done),
      .seed_mem_rd_en(s1_rd_en), .seed_mem_rd_addr(s1_addr), .seed_mem_rd_data(s1_rd_data),
      .seed_out(s1_seed), .seed_out_index(s1_idx), .seed_out_valid(s1_valid),
      .seed_out_ready(ready_small)
   );

   seed_stream_reader #(.SEED_NUM(64), .KEY_LEN(256)) dut64 (
      .clk(clk), .reset(rst), .start(start_small), .busy(s64_busy), .done(s64_done),
      .seed_mem_rd_en(s64_rd_en), .seed_mem_rd_addr(s64_addr), .seed_mem_rd_data(s64_rd_data),
      .seed_out(s64_seed), .seed_out_index(s64_idx), .seed_out_valid(s64_valid),
      .seed_out_ready(ready_small)
   );

   function automatic logic [255:0] seed_of(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {32{b}};
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: q is valid one cycle after the rd_en cycle.
   always @(posedge clk) begin
      if (rd_en)     rd_data     <= seed_of(int'(rd_addr));
      if (s1_rd_en)  s1_rd_data  <= seed_of(int'(s1_addr));
      if (s64_rd_en) s64_rd_data <= seed_of(int'(s64_addr));
   end

   task automatic check(input bit ok, input string name, input logic [255:0] act,
                        input logic [255:0] exp);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic ready_for(input vec_t v, input int rel);
      if (v.mode == 0) return 1'b1;
      if (v.mode == 1) return (rel > v.stall);
      return lfsr[0];
   endfunction

   task automatic run_vec(input vec_t v);
      int rel, next_idx, done_cnt, done_at, busy_cnt, first_valid, stall_rd;
      logic [6:0]   prev_idx;
      logic [255:0] prev_data;
      logic         prev_valid, prev_ready;
      bit           fin;
      rel = 0; next_idx = 0; done_cnt = 0; done_at = -1; busy_cnt = 0;
      first_valid = -1; stall_rd = 0; prev_valid = 1'b0; prev_ready = 1'b1;
      prev_idx = '0; prev_data = '0; fin = 0;
      @(posedge clk); #1;
      start = 1'b1;
      ready = ready_for(v, 0);
      while (!fin) begin
         @(negedge clk);
         if (prev_valid && !prev_ready) begin
            check(valid && idx == prev_idx && seed_out == prev_data, "hold_under_stall",
                  {idx, seed_out[7:0]}, {prev_idx, prev_data[7:0]});
         end
         if (valid && first_valid < 0) first_valid = rel;
         if (busy) busy_cnt++;
         if (v.mode == 1 && rel <= v.stall && rd_en) begin
            check(int'(rd_addr) == stall_rd, "stall_rd_addr", rd_addr, stall_rd);
            stall_rd++;
         end
         if (valid && ready) begin
            check(int'(idx) == next_idx, "index_order", idx, next_idx);
            check(seed_out == seed_of(next_idx), "seed_data", seed_out, seed_of(next_idx));
            next_idx++;
         end
         if (done) begin
            done_cnt++;
            done_at = rel;
         end
         prev_valid = valid; prev_ready = ready; prev_idx = idx; prev_data = seed_out;
         if ((done_cnt > 0 && rel >= done_at + 4) || rel > 400) fin = 1;
         @(posedge clk); #1;
         rel++;
         if (v.mode == 2) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         start = (v.restart != 0) && (rel == 30 || rel == v.exp_done);
         ready = ready_for(v, rel);
      end
      start = 1'b0;
      check(next_idx == 67, "seed_count", next_idx, 67);
      check(done_cnt == 1, "done_pulses", done_cnt, 1);
      check(first_valid == v.exp_first_valid, "first_valid_cycle", first_valid, v.exp_first_valid);
      if (v.exp_done >= 0) check(done_at == v.exp_done, "done_cycle", done_at, v.exp_done);
      if (v.exp_busy >= 0) check(busy_cnt == v.exp_busy, "busy_cycles", busy_cnt, v.exp_busy);
      if (v.exp_stall_rd >= 0) check(stall_rd == v.exp_stall_rd, "stall_rd_count", stall_rd, v.exp_stall_rd);
   endtask

   vec_t vecs[4];

   initial begin
      int hs, n1, n64, d1, d1_at, d64, d64_at;
      vecs[0] = '{mode: 0, stall: 0,  restart: 0, exp_first_valid: 3, exp_done: 70, exp_busy: 69, exp_stall_rd: -1};
      vecs[1] = '{mode: 1, stall: 20, restart: 0, exp_first_valid: 3, exp_done: 88, exp_busy: 87, exp_stall_rd: 2};
      vecs[2] = '{mode: 2, stall: 0,  restart: 0, exp_first_valid: 3, exp_done: -1, exp_busy: -1, exp_stall_rd: -1};
      vecs[3] = '{mode: 0, stall: 0,  restart: 1, exp_first_valid: 3, exp_done: 70, exp_busy: 69, exp_stall_rd: -1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check(!busy && !done && !rd_en && rd_addr == 7'd0, "reset_ctrl", {busy, done, rd_en, rd_addr}, 10'd0);
      check(!valid && idx == 7'd0 && seed_out == 256'd0, "reset_out", {valid, idx, seed_out[7:0]}, 16'd0);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset after ten accepted seeds aborts the stream.
      @(posedge clk); #1;
      start = 1'b1; ready = 1'b1; hs = 0;
      for (int c = 0; c < 100 && hs < 10; c++) begin
         @(negedge clk);
         if (valid && ready) hs++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      check(hs == 10, "abort_handshakes", hs, 10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check(!busy && !valid && !rd_en && !done, "abort_state", {busy, valid, rd_en, done}, 4'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check(!valid && !done && !busy, "abort_quiet", {valid, done, busy}, 3'd0);
      end
      run_vec(vecs[0]);

      // SEED_NUM=1 and SEED_NUM=64 instances streamed together with ready high.
      n1 = 0; n64 = 0; d1 = 0; d1_at = -1; d64 = 0; d64_at = -1;
      @(posedge clk); #1;
      start_small = 1'b1;
      for (int rel = 0; rel < 80; rel++) begin
         @(negedge clk);
         if (s1_valid) begin
            check(int'(s1_idx) == n1 && s1_seed == seed_of(n1), "n1_seed", s1_seed, seed_of(n1));
            n1++;
         end
         if (s64_valid) begin
            check(int'(s64_idx) == n64, "n64_index", s64_idx, n64);
            check(s64_seed == seed_of(n64), "n64_seed", s64_seed, seed_of(n64));
            n64++;
         end
         if (s1_done) begin d1++; d1_at = rel; end
         if (s64_done) begin d64++; d64_at = rel; end
         @(posedge clk); #1;
         start_small = 1'b0;
      end
      check(n1 == 1 && d1 == 1, "n1_count", {n1[7:0], d1[7:0]}, 16'h0101);
      check(d1_at == 4, "n1_done_cycle", d1_at, 4);
      check(n64 == 64 && d64 == 1, "n64_count", {n64[7:0], d64[7:0]}, 16'h4001);
      check(d64_at == 67, "n64_done_cycle", d64_at, 67);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
